// File: rtl/i2s_sample_serializer.sv
// I2S serializer for the Pmod I2S2 DAC: one-entry sample holding register,
// MCLK/SCLK/LRCK derived from a prescaled 9-bit phase counter, MSB-first data.
module i2s_sample_serializer #(
   parameter int unsigned MCLK_HALF_CYCLES = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] sample_data,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        mclk,
   output logic        lrck,
   output logic        sclk,
   output logic        sdout,
   output logic        underrun
);

   localparam int unsigned PW =
      (MCLK_HALF_CYCLES > 1) ? $clog2(MCLK_HALF_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(MCLK_HALF_CYCLES - 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [8:0]    ph_q, ph_d;
   logic [15:0]   cur_q, cur_d;
   logic [15:0]   shreg_q, shreg_d;
   logic [15:0]   hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          underrun_q, underrun_d;

   logic          tick;
   logic          accept;
   logic [8:0]    ph_nx;

   // Clocks come straight from registered phase bits, so they cannot glitch.
   assign mclk     = ph_q[0];
   assign sclk     = ph_q[3];
   assign lrck     = ph_q[8];
   assign sdout    = shreg_q[15];
   assign underrun = underrun_q;

   // Handshake and phase helpers shared by the next-state logic.
   always_comb begin
      sample_ready = (state_q == S_IDLE) | ~hold_full_q;
      accept       = sample_valid & sample_ready;
      tick         = (state_q == S_RUN) && (pre_q == PRE_MAX);
      ph_nx        = ph_q + 9'd1;
   end

   // Next-state: start on first sample, then free-run and feed the shifter.
   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      ph_d        = ph_q;
      cur_d       = cur_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = underrun_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               cur_d   = sample_data;
               shreg_d = sample_data;
               pre_d   = '0;
               ph_d    = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (accept) begin
               hold_d      = sample_data;
               hold_full_d = 1'b1;
            end
            if (tick) begin
               ph_d = ph_nx;
               if (ph_nx == 9'd0) begin
                  // Frame start: a drain here never overlaps an accept,
                  // because ready is low whenever hold is full.
                  if (hold_full_q) begin
                     cur_d       = hold_q;
                     shreg_d     = hold_q;
                     hold_full_d = 1'b0;
                  end else begin
                     cur_d      = '0;
                     shreg_d    = '0;
                     underrun_d = 1'b1;
                  end
               end else if (ph_nx == 9'd256) begin
                  shreg_d = cur_q;
               end else if (ph_nx[3:0] == 4'd0) begin
                  shreg_d = {shreg_q[14:0], 1'b0};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pre_q       <= '0;
         ph_q        <= '0;
         cur_q       <= '0;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         ph_q        <= ph_d;
         cur_q       <= cur_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         underrun_q  <= underrun_d;
      end
   end

endmodule

// File: tb/tb_i2s_sample_serializer.sv
// Bench for i2s_sample_serializer: two instances (half-cycles 2 and 1),
// time-based frame model, directed steps plus randomized sample streams.
module tb_i2s_sample_serializer;

   typedef struct packed {
      logic [15:0] d;
      int          t;
   } smp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid [2];
   logic [15:0] data  [2];
   logic        ready [2];
   logic        mclk  [2];
   logic        lrck  [2];
   logic        sclk  [2];
   logic        sdout [2];
   logic        urun  [2];

   always #4 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      i2s_sample_serializer #(
         .MCLK_HALF_CYCLES((g == 0) ? 2 : 1)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .sample_data  (data[g]),
         .sample_valid (valid[g]),
         .sample_ready (ready[g]),
         .mclk         (mclk[g]),
         .lrck         (lrck[g]),
         .sclk         (sclk[g]),
         .sdout        (sdout[g]),
         .underrun     (urun[g])
      );
   end

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          gap   = 0;
   smp_t        mq [2][$];
   logic [15:0] fq [2][$];
   bit          armed   [2];
   bit          hs_prev [2];
   bit          fell    [2];
   bit          exp_ur  [2];
   logic [15:0] exp_w   [2];
   logic [15:0] word    [2][2];
   int          cnt     [2][2];
   int          last_fall  [2];
   int          last_srise [2];
   int          last_mrise [2];
   logic        p_lrck [2];
   logic        p_sclk [2];
   logic        p_mclk [2];

   function automatic int nhalf(int g);
      return (g == 0) ? 2 : 1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_model(int g);
      armed[g]      = 1'b0;
      hs_prev[g]    = 1'b0;
      exp_ur[g]     = 1'b0;
      exp_w[g]      = '0;
      mq[g].delete();
      for (int c = 0; c < 2; c++) begin
         cnt[g][c]  = 0;
         word[g][c] = '0;
      end
      last_fall[g]  = -1;
      last_srise[g] = -1;
      last_mrise[g] = -1;
      p_lrck[g]     = 1'b0;
      p_sclk[g]     = 1'b0;
      p_mclk[g]     = 1'b0;
   endtask

   // One clock: observe on the falling edge, update model, drive inputs.
   task automatic step();
      smp_t s;
      int   ch;
      @(negedge clk);
      cyc++;
      for (int g = 0; g < 2; g++) begin
         fell[g] = 1'b0;
         if (!rst_n) begin
            clear_model(g);
            continue;
         end
         if (hs_prev[g]) begin
            if (!armed[g]) begin
               armed[g]     = 1'b1;
               exp_w[g]     = data[g];
               last_fall[g] = cyc;
               cnt[g][0]    = 0;
               cnt[g][1]    = 0;
            end else begin
               s.d = data[g];
               s.t = cyc;
               mq[g].push_back(s);
            end
            if (fq[g].size() > 0) void'(fq[g].pop_front());
            valid[g] = 1'b0;
         end
         if (p_lrck[g] && !lrck[g]) begin
            fell[g] = 1'b1;
            if (last_fall[g] >= 0)
               chk($sformatf("lrck_period%0d", g), cyc - last_fall[g],
                   512 * nhalf(g));
            last_fall[g] = cyc;
            if (mq[g].size() > 0 && mq[g][0].t < cyc) begin
               exp_w[g] = mq[g][0].d;
               void'(mq[g].pop_front());
            end else begin
               exp_w[g]  = '0;
               exp_ur[g] = 1'b1;
            end
            chk($sformatf("underrun_at_fall%0d", g), urun[g], exp_ur[g]);
         end
         if (!p_sclk[g] && sclk[g]) begin
            if (last_srise[g] >= 0)
               chk($sformatf("sclk_period%0d", g), cyc - last_srise[g],
                   16 * nhalf(g));
            last_srise[g] = cyc;
            ch = lrck[g] ? 1 : 0;
            word[g][ch] = {word[g][ch][14:0], sdout[g]};
            cnt[g][ch]++;
            if (cnt[g][ch] == 16) begin
               chk($sformatf("data%0d_ch%0d", g, ch), word[g][ch], exp_w[g]);
               chk($sformatf("underrun%0d", g), urun[g], exp_ur[g]);
               cnt[g][ch] = 0;
            end
         end
         if (!p_mclk[g] && mclk[g]) begin
            if (last_mrise[g] >= 0)
               chk($sformatf("mclk_period%0d", g), cyc - last_mrise[g],
                   2 * nhalf(g));
            last_mrise[g] = cyc;
         end
         p_lrck[g] = lrck[g];
         p_sclk[g] = sclk[g];
         p_mclk[g] = mclk[g];
         if (!valid[g] && fq[g].size() > 0 &&
             int'($urandom_range(0, 99)) >= gap) begin
            valid[g] = 1'b1;
            data[g]  = fq[g][0];
         end
         hs_prev[g] = valid[g] && ready[g];
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         valid[g] = 1'b0;
         fq[g].delete();
      end
   endtask

   initial begin
      logic        pr;
      logic [15:0] r;
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         valid[g] = 1'b0;
         data[g]  = '0;
         clear_model(g);
      end
      step();
      step();
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("rst_clocks%0d", g),
             {mclk[g], sclk[g], lrck[g], sdout[g], urun[g]}, 0);
         chk($sformatf("rst_ready%0d", g), ready[g], 1);
      end
      rst_n = 1'b1;
      step();
      chk("post_rst_out0", {mclk[0], sclk[0], lrck[0], sdout[0], urun[0]}, 0);
      chk("post_rst_rdy0", ready[0], 1);

      for (int g = 0; g < 2; g++) begin
         fq[g].push_back(16'hA5C3);
         fq[g].push_back(16'hA5C3);
         fq[g].push_back(16'h0001);
         fq[g].push_back(16'h8000);
         fq[g].push_back(16'h7FFF);
         fq[g].push_back(16'hFFFF);
      end
      for (int i = 0; i < 6; i++) begin
         r = 16'($urandom);
         fq[0].push_back(r);
         fq[1].push_back(r);
      end
      step();
      step();
      chk("rdy_after_idle_accept", ready[0], 1);
      chk("msb_next_cycle", sdout[0], 1);
      step();
      chk("rdy_drop", ready[0], 0);

      pr = ready[0];
      for (int i = 0; i < 3000 && !fell[0]; i++) begin
         pr = ready[0];
         step();
      end
      chk("first_fall_seen", fell[0], 1);
      chk("stall_ready_low", pr, 0);
      chk("ready_at_drain", ready[0], 1);
      step();
      chk("accept_after_drain", ready[0], 0);

      gap = 50;
      for (int i = 0; i < 15000; i++) step();
      chk("underrun_sticky0", urun[0], 1);
      chk("underrun_sticky1", urun[1], 1);

      for (int i = 0; i < 2000 && !(lrck[0] && cnt[0][1] > 4); i++) step();
      chk("in_right_channel", lrck[0], 1);
      do_reset();
      step();
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("mid_rst_out%0d", g),
             {mclk[g], sclk[g], lrck[g], sdout[g], urun[g]}, 0);
         chk($sformatf("mid_rst_rdy%0d", g), ready[g], 1);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         step();
         chk("idle_quiet", {mclk[0], sclk[0], lrck[0], sdout[0], urun[0]}, 0);
      end

      gap = 0;
      for (int i = 0; i < 8; i++) fq[1].push_back(16'($urandom));
      for (int i = 0; i < 9 * 512 + 100; i++) step();
      chk("n1_underrun_end", urun[1], exp_ur[1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
